// File: rtl/operand_sequencer_pkg.sv
// operand_sequencer_pkg: FSM state encodings and default widths shared by the sequencer, its FIFO and the bench
package operand_sequencer_pkg;
    localparam int OPSEQ_W     = 8;
    localparam int OPSEQ_DEPTH = 4;
    localparam int OPSEQ_LEN_W = 8;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/operand_sequencer_fifo.sv
// opseq_fifo: synchronous operand-pair FIFO with registered full/empty; OPSEQ_LEVEL_EN exposes occupancy
module opseq_fifo
    import operand_sequencer_pkg::*;
#(
    parameter int W2    = 2 * OPSEQ_W,
    parameter int DEPTH = OPSEQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     r,
    input  logic                     push,
    input  logic [W2-1:0]            din,
    input  logic                     pop,
    output logic [W2-1:0]            dout,
    output logic                     full,
`ifdef OPSEQ_LEVEL_EN
    output logic [$clog2(DEPTH):0]   level,
`endif
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W2-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    // full/empty come from the level register only, so a same-cycle pop never raises ready
    assign full   = r_level == (AW+1)'(DEPTH);
    assign empty  = r_level == '0;
    assign dout   = r_mem[r_rd];
`ifdef OPSEQ_LEVEL_EN
    assign level  = r_level;
`endif
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end
endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: buffers (a,b) pairs and streams exactly len of them into an enable-less MAC
// OPSEQ_LEVEL_EN adds the level and bubbles observation ports
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int W     = OPSEQ_W,
    parameter int DEPTH = OPSEQ_DEPTH,
    parameter int LEN_W = OPSEQ_LEN_W
) (
    input  logic                   clk,
    input  logic                   r,
    input  logic                   in_valid,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    output logic                   in_ready,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    output logic [W-1:0]           acc_a,
    output logic [W-1:0]           acc_b,
    output logic                   acc_clr,
    output logic                   busy,
`ifdef OPSEQ_LEVEL_EN
    output logic [$clog2(DEPTH):0] level,
    output logic [LEN_W-1:0]       bubbles,
`endif
    output logic                   done
);
    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_rem;
    logic [W-1:0]     r_acc_a;
    logic [W-1:0]     r_acc_b;
    logic             r_acc_clr;
    logic             r_busy;
    logic             r_done;
    logic [2*W-1:0]   w_dout;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_bubble;
    logic             w_start;
    opseq_fifo #(.W2(2 * W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .r     (r),
        .push  (in_valid),
        .din   ({in_a, in_b}),
        .pop   (w_pop),
        .dout  (w_dout),
        .full  (w_full),
`ifdef OPSEQ_LEVEL_EN
        .level (level),
`endif
        .empty (w_empty)
    );
    assign in_ready = !w_full;
    assign w_start  = (r_state == ST_IDLE) && start;
    // the pop decision is made while entering/staying in STREAM so the pair is on acc_a/b during that cycle
    always_comb begin
        w_next   = r_state;
        w_pop    = 1'b0;
        w_bubble = 1'b0;
        case (r_state)
            ST_IDLE: w_next = start ? ST_CLEAR : ST_IDLE;
            ST_CLEAR, ST_STREAM: begin
                w_next   = (r_rem == '0) ? ST_DONE : ST_STREAM;
                w_pop    = (r_rem != '0) && !w_empty;
                w_bubble = (r_rem != '0) && w_empty;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_state   <= ST_IDLE;
            r_rem     <= '0;
            r_acc_a   <= '0;
            r_acc_b   <= '0;
            r_acc_clr <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rem     <= w_start ? len : w_pop ? r_rem - 1'b1 : r_rem;
            r_acc_a   <= w_pop ? w_dout[2*W-1:W] : '0;
            r_acc_b   <= w_pop ? w_dout[W-1:0] : '0;
            r_acc_clr <= w_next == ST_CLEAR;
            r_busy    <= w_next != ST_IDLE;
            r_done    <= w_next == ST_DONE;
        end
    end
`ifdef OPSEQ_LEVEL_EN
    logic [LEN_W-1:0] r_bubbles;
    assign bubbles = r_bubbles;
    always_ff @(posedge clk or posedge r) begin
        if (r) r_bubbles <= '0;
        else if (w_start) r_bubbles <= '0;
        else if (w_bubble && r_bubbles != '1) r_bubbles <= r_bubbles + 1'b1;
    end
`endif
    assign acc_a   = r_acc_a;
    assign acc_b   = r_acc_b;
    assign acc_clr = r_acc_clr;
    assign busy    = r_busy;
    assign done    = r_done;
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: table-driven frames plus corner sequences, scoreboarded against a MAC model
module tb_operand_sequencer;
    import operand_sequencer_pkg::*;
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;
    typedef struct {
        logic [31:0] av;
        logic [31:0] bv;
        int          n;
        int          len;
        logic [7:0]  exp_s;
    } vec_t;
    logic       clk;
    logic       r;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_ready;
    logic       start;
    logic [7:0] len;
    logic [7:0] acc_a;
    logic [7:0] acc_b;
    logic       acc_clr;
    logic       busy;
    logic       done;
`ifdef OPSEQ_LEVEL_EN
    logic [2:0] level;
    logic [7:0] bubbles;
`endif
    logic [7:0] s;
    logic [7:0] exp_dot;
    pair_t      q[$];
    int         n_chk;
    int         n_err;
    int         n_done;
    int         n_bubble;
    operand_sequencer dut (
        .clk      (clk),
        .r        (r),
        .in_valid (in_valid),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_ready (in_ready),
        .start    (start),
        .len      (len),
        .acc_a    (acc_a),
        .acc_b    (acc_b),
        .acc_clr  (acc_clr),
        .busy     (busy),
`ifdef OPSEQ_LEVEL_EN
        .level    (level),
        .bubbles  (bubbles),
`endif
        .done     (done)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // downstream accumulator: adds a*b every edge, synchronous clear, 8-bit wrap
    always @(posedge clk) s <= acc_clr ? 8'd0 : 8'(16'(s) + 16'(acc_a) * 16'(acc_b));
    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!r) begin
            if (acc_clr) exp_dot = 8'd0;
            if (acc_a != 8'd0 || acc_b != 8'd0) begin
                if (q.size() == 0) chk("unexpected_pair", int'({acc_a, acc_b}), 0);
                else begin
                    pair_t e;
                    e = q.pop_front();
                    chk("pair", int'({acc_a, acc_b}), int'({e.a, e.b}));
                    exp_dot = 8'(16'(exp_dot) + 16'(e.a) * 16'(e.b));
                end
            end else if (busy && !acc_clr && !done) n_bubble++;
            if (done) begin
                n_done++;
                chk("done_sum_model", int'(s), int'(exp_dot));
            end
        end
    end
    task automatic push_pair(input logic [7:0] a, input logic [7:0] b, output bit ok);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        ok       = in_ready;
        @(posedge clk);
        if (ok) q.push_back('{a: a, b: b});
        #1 in_valid = 1'b0;
    endtask
    task automatic start_frame(input int ln);
        @(negedge clk);
        start = 1'b1;
        len   = 8'(ln);
        @(posedge clk);
        #1 start = 1'b0;
        chk("clr_on_start", int'(acc_clr), 1);
        chk("state_clear", int'(dut.r_state), int'(ST_CLEAR));
    endtask
    task automatic wait_done(input logic [7:0] exp_s, input string nm, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 60);
        chk({nm, "_done"}, int'(done), 1);
        chk({nm, "_sum"}, int'(s), int'(exp_s));
        @(negedge clk);
        chk({nm, "_pulse"}, int'(done), 0);
        chk({nm, "_busy"}, int'(busy), 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        vec_t tbl[5];
        bit   ok;
        int   cyc;
        int   d0;
        int   b0;
        tbl[0] = '{av: 32'h00020401, bv: 32'h00030501, n: 3, len: 3, exp_s: 8'd27};
        tbl[1] = '{av: 32'h00000302, bv: 32'h00000302, n: 2, len: 2, exp_s: 8'd13};
        tbl[2] = '{av: 32'h000002FF, bv: 32'h0000C8FF, n: 2, len: 2, exp_s: 8'd145};
        tbl[3] = '{av: 32'h05030107, bv: 32'h01030209, n: 4, len: 4, exp_s: 8'd79};
        tbl[4] = '{av: 32'h0, bv: 32'h0, n: 0, len: 0, exp_s: 8'd0};
        n_chk = 0; n_err = 0; n_done = 0; n_bubble = 0; exp_dot = 8'd0;
        r = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; start = 1'b0; len = '0;
        repeat (2) @(negedge clk);
        chk("rst_acc_clr", int'(acc_clr), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_acc", int'({acc_a, acc_b}), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_s", int'(s), 0);
        r = 1'b0;
        #1 chk("rst_state", int'(dut.r_state), int'(ST_IDLE));
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                push_pair(tbl[i].av[j*8 +: 8], tbl[i].bv[j*8 +: 8], ok);
                chk("vec_push", int'(ok), 1);
            end
            start_frame(tbl[i].len);
            wait_done(tbl[i].exp_s, $sformatf("vec%0d", i), cyc);
            chk("vec_latency", cyc, tbl[i].len + 2);
            chk("vec_drained", q.size(), 0);
        end
        // len=0 leaves queued pairs untouched for the next frame
        push_pair(8'd9, 8'd9, ok);
        start_frame(0);
        wait_done(8'd0, "len0", cyc);
        chk("len0_latency", cyc, 2);
        chk("len0_kept", q.size(), 1);
`ifdef OPSEQ_LEVEL_EN
        chk("len0_level", int'(level), 1);
`endif
        start_frame(1);
        wait_done(8'd81, "len0_next", cyc);
        // second pair arrives late: three bubbles, one done
        d0 = n_done;
        push_pair(8'd4, 8'd5, ok);
        start_frame(2);
        b0 = n_bubble;
        repeat (3) @(posedge clk);
        push_pair(8'd0, 8'd7, ok);
        wait_done(8'd20, "late", cyc);
        chk("late_bubbles", n_bubble - b0, 3);
        chk("late_done_once", n_done - d0, 1);
`ifdef OPSEQ_LEVEL_EN
        chk("late_bubble_port", int'(bubbles), 3);
`endif
        // fill a DEPTH=4 FIFO with five pairs
        for (int i = 0; i < 5; i++) begin
            push_pair(8'(i + 1), 8'(i + 2), ok);
            chk("full_push_ok", int'(ok), int'(i < 4));
        end
        chk("full_ready", int'(in_ready), 0);
`ifdef OPSEQ_LEVEL_EN
        chk("full_level", int'(level), 4);
`endif
        start_frame(4);
        wait_done(8'd40, "full", cyc);
        chk("full_ready_after", int'(in_ready), 1);
        // reset in the middle of a stream
        d0 = n_done;
        push_pair(8'd1, 8'd1, ok);
        push_pair(8'd2, 8'd2, ok);
        push_pair(8'd3, 8'd3, ok);
        start_frame(3);
        @(posedge clk);
        @(posedge clk);
        #2 r = 1'b1;
        q.delete();
        #1;
        chk("mid_rst_acc", int'({acc_a, acc_b}), 0);
        chk("mid_rst_clr", int'(acc_clr), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        @(posedge clk);
        #1 chk("mid_rst_s", int'(s), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        @(negedge clk);
        r = 1'b0;
        #1 chk("clr_hold", int'(acc_clr), 1);
        @(posedge clk);
        #1 chk("clr_drop", int'(acc_clr), 0);
        chk("mid_rst_no_done", n_done - d0, 0);
        push_pair(8'd1, 8'd1, ok);
        start_frame(1);
        wait_done(8'd1, "after_rst", cyc);
        // start ignored mid-frame; push and pop share an edge
        d0 = n_done;
        push_pair(8'd1, 8'd2, ok);
        push_pair(8'd3, 8'd4, ok);
        start_frame(3);
        @(posedge clk);
        #1;
`ifdef OPSEQ_LEVEL_EN
        chk("pp_level_before", int'(level), 1);
`endif
        start = 1'b1;
        len   = 8'd9;
        push_pair(8'd5, 8'd6, ok);
`ifdef OPSEQ_LEVEL_EN
        chk("pp_level_after", int'(level), 1);
`endif
        start = 1'b0;
        wait_done(8'd44, "restart", cyc);
        repeat (5) @(negedge clk);
        chk("restart_done_once", n_done - d0, 1);
        chk("restart_idle", int'(busy), 0);
        chk("restart_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
